// File: rtl/keypad_pkg.sv
`timescale 1ns/1ps
// keypad_pkg: shared constants and state encoding for the keypad entry block.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: key code constants, FSM state enum, entry geometry, digit test helper.
// Optional feature macro used by the design: KEYPAD_DEBOUNCE_EN.
package keypad_pkg;

    localparam int PW_DIGITS = 4;
    localparam int DISPLAY_W = 16;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        SUBMIT = 2'd2,
        LOCKED = 2'd3
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/key_event_detect.sv
`timescale 1ns/1ps
// key_event_detect: turns the raw asynchronous keypad level into a one-cycle key event.
// Latency: raw edge to KEY_EVT is 2 cycles (2+DEBOUNCE_CYCLES with KEYPAD_DEBOUNCE_EN).
// Backpressure: none; events are pulses and the consumer must take them when they occur.
// Ports: CLK, RST (sync, active high), KEY_PRESS/KEY_CODE raw inputs,
//        KEY_EVT one-cycle pulse on a new press, KEY_VAL code belonging to that press.
// Macro: KEYPAD_DEBOUNCE_EN adds a stable-level filter of DEBOUNCE_CYCLES cycles.
module key_event_detect
    import keypad_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd10_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KEY_PRESS,
    input  logic [3:0] KEY_CODE,
    output logic       KEY_EVT,
    output logic [3:0] KEY_VAL
);

    // Two-flop synchronizer for both the press level and the code.
    logic       press_s1_q, press_s1_d;
    logic       press_s2_q, press_s2_d;
    logic [3:0] code_s1_q, code_s1_d;
    logic [3:0] code_s2_q, code_s2_d;

    always_comb begin
        press_s1_d = KEY_PRESS;
        press_s2_d = press_s1_q;
        code_s1_d  = KEY_CODE;
        code_s2_d  = code_s1_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            press_s1_q <= 1'b0;
            press_s2_q <= 1'b0;
            code_s1_q  <= 4'h0;
            code_s2_q  <= 4'h0;
        end else begin
            press_s1_q <= press_s1_d;
            press_s2_q <= press_s2_d;
            code_s1_q  <= code_s1_d;
            code_s2_q  <= code_s2_d;
        end
    end

`ifdef KEYPAD_DEBOUNCE_EN
    // The debounced level follows the synchronized level only after it has
    // differed for DEBOUNCE_CYCLES consecutive cycles; any return resets the count.
    logic [15:0] db_cnt_q, db_cnt_d;
    logic        db_lvl_q, db_lvl_d;
    logic        db_prev_q, db_prev_d;
    logic [3:0]  code_q, code_d;

    always_comb begin
        db_cnt_d  = 16'd0;
        db_lvl_d  = db_lvl_q;
        db_prev_d = db_lvl_q;
        code_d    = code_q;
        if (press_s2_q != db_lvl_q) begin
            if (db_cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
                db_lvl_d = press_s2_q;
                // Code is captured at the moment the debounced level rises.
                if (press_s2_q) begin
                    code_d = code_s2_q;
                end
            end else begin
                db_cnt_d = db_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            db_cnt_q  <= 16'd0;
            db_lvl_q  <= 1'b0;
            db_prev_q <= 1'b0;
            code_q    <= 4'h0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            db_lvl_q  <= db_lvl_d;
            db_prev_q <= db_prev_d;
            code_q    <= code_d;
        end
    end

    assign KEY_EVT = db_lvl_q & ~db_prev_q;
    assign KEY_VAL = code_q;
`else
    logic press_prev_q, press_prev_d;

    always_comb begin
        press_prev_d = press_s2_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            press_prev_q <= 1'b0;
        end else begin
            press_prev_q <= press_prev_d;
        end
    end

    // Edge is combinational off the synchronizer so the FSM sees it in the third cycle.
    assign KEY_EVT = press_s2_q & ~press_prev_q;
    assign KEY_VAL = code_s2_q;

    // Without debounce the filter length has no meaning; keep the parameter
    // referenced so both builds share one interface.
    if (DEBOUNCE_CYCLES == 16'd0) begin : g_no_debounce_len
    end
`endif

endmodule

// File: rtl/keypad_entry.sv
`timescale 1ns/1ps
// keypad_entry: builds a 4-digit BCD entry from key presses and submits it with a STAR pulse.
// Latency: raw key edge to DISPLAY/DIGIT_CNT update is 3 cycles (3+DEBOUNCE_CYCLES with debounce).
// Backpressure: none; key events arriving in SUBMIT or LOCKED are dropped.
// Ports: CLK, RST (sync, active high), KEY_PRESS, KEY_CODE[3:0], ALERT, CLOSE_SENSOR in;
//        DISPLAY[15:0] (newest digit in [3:0]), STAR, DIGIT_CNT[2:0], ENTRY_BUSY out.
// Macro: KEYPAD_DEBOUNCE_EN enables the debounce filter in key_event_detect.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd50_000_000,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd10_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        KEY_PRESS,
    input  logic [3:0]  KEY_CODE,
    input  logic        ALERT,
    input  logic        CLOSE_SENSOR,
    output logic [15:0] DISPLAY,
    output logic        STAR,
    output logic [2:0]  DIGIT_CNT,
    output logic        ENTRY_BUSY
);

    localparam logic [2:0] FULL_CNT = 3'(PW_DIGITS);

    logic       key_evt;
    logic [3:0] key_val;

    key_event_detect #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_event_detect (
        .CLK       (CLK),
        .RST       (RST),
        .KEY_PRESS (KEY_PRESS),
        .KEY_CODE  (KEY_CODE),
        .KEY_EVT   (key_evt),
        .KEY_VAL   (key_val)
    );

    state_t                 state_q, state_d;
    logic [DISPLAY_W-1:0]   disp_q, disp_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   star_q, star_d;
    logic                   busy_q, busy_d;
    logic [31:0]            timer_q, timer_d;

    logic [31:0] timer_inc;
    logic        timeout;

    always_comb begin
        // Saturate rather than wrap so a huge TIMEOUT_CYCLES can never alias.
        timer_inc = (timer_q == 32'hFFFF_FFFF) ? timer_q : timer_q + 32'd1;
        timeout   = (timer_q == TIMEOUT_CYCLES - 32'd1);

        state_d = state_q;
        disp_d  = disp_q;
        cnt_d   = cnt_q;
        timer_d = 32'd0;

        if (ALERT) begin
            // Alarm beats everything, including a '*' arriving in the same cycle.
            state_d = LOCKED;
            disp_d  = '0;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_evt && is_digit(key_val)) begin
                        disp_d  = {{(DISPLAY_W-4){1'b0}}, key_val};
                        cnt_d   = 3'd1;
                        state_d = ENTRY;
                    end
                end
                ENTRY: begin
                    if (CLOSE_SENSOR) begin
                        state_d = IDLE;
                        disp_d  = '0;
                        cnt_d   = 3'd0;
                    end else if (key_evt) begin
                        // Any event, even an ignored code, restarts the idle window;
                        // this also lets an event win over a same-cycle expiry.
                        if (is_digit(key_val)) begin
                            if (cnt_q < FULL_CNT) begin
                                disp_d = {disp_q[DISPLAY_W-5:0], key_val};
                                cnt_d  = cnt_q + 3'd1;
                            end
                        end else if (key_val == KEY_STAR) begin
                            if (cnt_q == FULL_CNT) begin
                                state_d = SUBMIT;
                            end
                        end else if (key_val == KEY_HASH) begin
                            state_d = IDLE;
                            disp_d  = '0;
                            cnt_d   = 3'd0;
                        end
                    end else if (timeout) begin
                        state_d = IDLE;
                        disp_d  = '0;
                        cnt_d   = 3'd0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                SUBMIT: begin
                    // DISPLAY was held for the STAR cycle; clear on the way out.
                    state_d = IDLE;
                    disp_d  = '0;
                    cnt_d   = 3'd0;
                end
                LOCKED: begin
                    // ALERT is low here, i.e. it has just fallen.
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    disp_d  = '0;
                    cnt_d   = 3'd0;
                end
            endcase
        end

        star_d = (state_d == SUBMIT);
        busy_d = (state_d == ENTRY) || (state_d == SUBMIT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            disp_q  <= '0;
            cnt_q   <= 3'd0;
            star_q  <= 1'b0;
            busy_q  <= 1'b0;
            timer_q <= 32'd0;
        end else begin
            state_q <= state_d;
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            star_q  <= star_d;
            busy_q  <= busy_d;
            timer_q <= timer_d;
        end
    end

    assign DISPLAY    = disp_q;
    assign STAR       = star_q;
    assign DIGIT_CNT  = cnt_q;
    assign ENTRY_BUSY = busy_q;

endmodule

// File: tb/tb_keypad_entry.sv
`timescale 1ns/1ps
// tb_keypad_entry: self-checking bench for keypad_entry.
// Submitted entries are queued when '*' is driven and compared when STAR fires.
// Build with KEYPAD_DEBOUNCE_EN to also exercise the debounce filter.
module tb_keypad_entry;
    import keypad_pkg::*;

    localparam logic [31:0] TMO = 32'd100;
    localparam logic [15:0] DEB = 16'd8;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam int LAT = 3 + 8;
`else
    localparam int LAT = 3;
`endif
    localparam int HOLD = LAT + 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        KEY_PRESS;
    logic [3:0]  KEY_CODE;
    logic        ALERT;
    logic        CLOSE_SENSOR;
    logic [15:0] DISPLAY;
    logic        STAR;
    logic [2:0]  DIGIT_CNT;
    logic        ENTRY_BUSY;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    keypad_entry #(
        .TIMEOUT_CYCLES  (TMO),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .KEY_PRESS    (KEY_PRESS),
        .KEY_CODE     (KEY_CODE),
        .ALERT        (ALERT),
        .CLOSE_SENSOR (CLOSE_SENSOR),
        .DISPLAY      (DISPLAY),
        .STAR         (STAR),
        .DIGIT_CNT    (DIGIT_CNT),
        .ENTRY_BUSY   (ENTRY_BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        KEY_CODE  = code;
        KEY_PRESS = 1'b1;
        tick(HOLD);
        KEY_PRESS = 1'b0;
        tick(HOLD);
    endtask

    // Scoreboard side: every STAR pulse must match the oldest queued entry.
    always @(negedge CLK) begin
        if (!RST && STAR === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("star_unexpected", {31'd0, STAR}, 32'd0);
            end else begin
                check("star_display", {16'd0, DISPLAY}, {16'd0, exp_q.pop_front()});
                check("star_cnt", {29'd0, DIGIT_CNT}, 32'd4);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; KEY_PRESS = 1'b0; KEY_CODE = 4'h0; ALERT = 1'b0; CLOSE_SENSOR = 1'b0;
        tick(3);
        check("rst_display", {16'd0, DISPLAY}, 32'h0);
        check("rst_star", {31'd0, STAR}, 32'd0);
        check("rst_cnt", {29'd0, DIGIT_CNT}, 32'd0);
        check("rst_busy", {31'd0, ENTRY_BUSY}, 32'd0);
        RST = 1'b0;
        tick(2);

        // 1,2,3,4,'*' with exact STAR timing
        press(4'd1); press(4'd2);
        check("two_digits", {16'd0, DISPLAY}, 32'h0012);
        press(4'd3); press(4'd4);
        check("four_digits", {16'd0, DISPLAY}, 32'h1234);
        check("four_cnt", {29'd0, DIGIT_CNT}, 32'd4);
        exp_q.push_back(16'h1234);
        KEY_CODE = KEY_STAR; KEY_PRESS = 1'b1;
        tick(LAT - 1);
        check("star_early", {31'd0, STAR}, 32'd0);
        tick(1);
        check("star_high", {31'd0, STAR}, 32'd1);
        check("submit_display", {16'd0, DISPLAY}, 32'h1234);
        check("submit_busy", {31'd0, ENTRY_BUSY}, 32'd1);
        tick(1);
        check("star_one_cycle", {31'd0, STAR}, 32'd0);
        check("post_submit_display", {16'd0, DISPLAY}, 32'h0);
        check("post_submit_cnt", {29'd0, DIGIT_CNT}, 32'd0);
        check("post_submit_busy", {31'd0, ENTRY_BUSY}, 32'd0);
        KEY_PRESS = 1'b0;
        tick(HOLD);

        // Non-digits in IDLE are ignored
        press(KEY_STAR); press(KEY_HASH); press(4'hC);
        check("idle_ignore_disp", {16'd0, DISPLAY}, 32'h0);
        check("idle_ignore_busy", {31'd0, ENTRY_BUSY}, 32'd0);

        // Fifth digit ignored, then submit 5678
        press(4'd5); press(4'd6); press(4'd7); press(4'd8); press(4'd9);
        check("no_wrap", {16'd0, DISPLAY}, 32'h5678);
        check("no_wrap_cnt", {29'd0, DIGIT_CNT}, 32'd4);
        exp_q.push_back(16'h5678);
        press(KEY_STAR);
        check("after_5678", {29'd0, DIGIT_CNT}, 32'd0);

        // Short entry: '*' ignored, entry kept
        press(4'd1); press(4'd2); press(KEY_STAR);
        check("short_star_disp", {16'd0, DISPLAY}, 32'h0012);
        check("short_star_cnt", {29'd0, DIGIT_CNT}, 32'd2);
        check("short_star_busy", {31'd0, ENTRY_BUSY}, 32'd1);
        press(4'hF);
        check("entry_ignore_f", {16'd0, DISPLAY}, 32'h0012);
        press(KEY_HASH);
        check("hash_clear", {16'd0, DISPLAY}, 32'h0);

        // 3,4,'#'
        press(4'd3); press(4'd4);
        check("disp_34", {16'd0, DISPLAY}, 32'h0034);
        press(KEY_HASH);
        check("hash_cnt", {29'd0, DIGIT_CNT}, 32'd0);
        check("hash_busy", {31'd0, ENTRY_BUSY}, 32'd0);

        // Timeout exactly TMO cycles after the accepted event
        KEY_CODE = 4'd7; KEY_PRESS = 1'b1;
        tick(LAT - 1);
        check("latency_before", {29'd0, DIGIT_CNT}, 32'd0);
        tick(1);
        check("latency_at", {29'd0, DIGIT_CNT}, 32'd1);
        tick(99);
        check("tmo_99", {16'd0, DISPLAY}, 32'h0007);
        tick(1);
        check("tmo_100", {16'd0, DISPLAY}, 32'h0);
        check("tmo_busy", {31'd0, ENTRY_BUSY}, 32'd0);
        KEY_PRESS = 1'b0;
        tick(HOLD);

        // Key event landing on the expiry cycle wins
        KEY_CODE = 4'd1; KEY_PRESS = 1'b1;
        tick(LAT);
        KEY_PRESS = 1'b0;
        tick(100 - LAT);
        KEY_CODE = 4'd2; KEY_PRESS = 1'b1;
        tick(LAT);
        check("evt_vs_tmo", {16'd0, DISPLAY}, 32'h0012);
        KEY_PRESS = 1'b0;
        tick(HOLD);
        press(KEY_HASH);

        // ALERT with the '*' event in the same cycle
        press(4'd4); press(4'd3); press(4'd2); press(4'd1);
        KEY_CODE = KEY_STAR; KEY_PRESS = 1'b1;
        tick(LAT - 1);
        ALERT = 1'b1;
        tick(1);
        check("alert_star", {31'd0, STAR}, 32'd0);
        check("alert_display", {16'd0, DISPLAY}, 32'h0);
        check("alert_cnt", {29'd0, DIGIT_CNT}, 32'd0);
        check("alert_busy", {31'd0, ENTRY_BUSY}, 32'd0);
        KEY_PRESS = 1'b0;
        tick(HOLD);
        press(4'd5);
        check("locked_key", {29'd0, DIGIT_CNT}, 32'd0);
        KEY_CODE = 4'd6; KEY_PRESS = 1'b1;
        tick(HOLD);
        ALERT = 1'b0;
        tick(20);
        check("held_at_unlock", {29'd0, DIGIT_CNT}, 32'd0);
        KEY_PRESS = 1'b0;
        tick(HOLD);
        press(4'd8);
        check("fresh_after_unlock", {16'd0, DISPLAY}, 32'h0008);
        press(KEY_HASH);

        // Door close discards a partial entry
        press(4'd9); press(4'd1);
        CLOSE_SENSOR = 1'b1;
        tick(1);
        CLOSE_SENSOR = 1'b0;
        check("close_display", {16'd0, DISPLAY}, 32'h0);
        check("close_cnt", {29'd0, DIGIT_CNT}, 32'd0);

        // 1000-cycle hold: one event, then timeout, no further events
        KEY_CODE = 4'd3; KEY_PRESS = 1'b1;
        tick(LAT);
        check("hold_first", {29'd0, DIGIT_CNT}, 32'd1);
        tick(99);
        check("hold_99", {29'd0, DIGIT_CNT}, 32'd1);
        tick(1);
        check("hold_tmo", {29'd0, DIGIT_CNT}, 32'd0);
        tick(1000 - LAT - 100);
        check("hold_1000", {29'd0, DIGIT_CNT}, 32'd0);
        KEY_PRESS = 1'b0;
        tick(HOLD);
        check("hold_release", {29'd0, DIGIT_CNT}, 32'd0);

        // RST mid-entry
        press(4'd4); press(4'd5); press(4'd6);
        check("pre_rst_cnt", {29'd0, DIGIT_CNT}, 32'd3);
        RST = 1'b1;
        tick(1);
        check("mid_rst_display", {16'd0, DISPLAY}, 32'h0);
        check("mid_rst_cnt", {29'd0, DIGIT_CNT}, 32'd0);
        check("mid_rst_busy", {31'd0, ENTRY_BUSY}, 32'd0);
        check("mid_rst_star", {31'd0, STAR}, 32'd0);
        RST = 1'b0;
        tick(2);
        press(4'd2);
        check("after_rst_digit", {16'd0, DISPLAY}, 32'h0002);
        press(KEY_HASH);

`ifdef KEYPAD_DEBOUNCE_EN
        // Bouncing shorter than the filter never produces an event
        KEY_CODE = 4'd2;
        for (int i = 0; i < 10; i++) begin
            KEY_PRESS = ~KEY_PRESS;
            tick(3);
        end
        tick(HOLD);
        check("bounce", {29'd0, DIGIT_CNT}, 32'd0);
        KEY_PRESS = 1'b1;
        tick(LAT - 1);
        check("deb_before", {29'd0, DIGIT_CNT}, 32'd0);
        tick(1);
        check("deb_at", {29'd0, DIGIT_CNT}, 32'd1);
        KEY_PRESS = 1'b0;
        tick(HOLD);
        press(KEY_HASH);
`endif

        tick(5);
        check("sb_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Keypad-side producer for the door-lock password comparator.
- Converts single key presses into a 4-digit BCD entry on DISPLAY.
- Issues a one-cycle STAR submit pulse while DISPLAY is held stable, then clears.
- Handles clear ('#'), inactivity timeout, door close and alarm lockout, so the comparator always samples a complete, stable entry.

Parameters:
- TIMEOUT_CYCLES, 32'd50_000_000: idle cycles in ENTRY before the partial entry is discarded.
- DEBOUNCE_CYCLES, 16'd10_000: stable-level cycles required before a press is accepted. Used only with KEYPAD_DEBOUNCE_EN.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- KEY_PRESS  input  1  raw keypad "any key down" level, asynchronous to CLK.
- KEY_CODE  input  4  key code while KEY_PRESS is high: 0-9 digit, 4'hA '*', 4'hB '#', 4'hC-4'hF ignored.
- ALERT  input  1  alarm from comparator; while high, entry is locked out.
- CLOSE_SENSOR  input  1  door-closed indication; clears any partial entry.
- DISPLAY  output  16  four BCD digits; newest digit in [3:0], oldest in [15:12].
- STAR  output  1  one-cycle submit pulse; DISPLAY is valid and stable in that cycle.
- DIGIT_CNT  output  3  number of digits entered, 0..4.
- ENTRY_BUSY  output  1  high in ENTRY or SUBMIT state.

Behaviour:
- Reset: DISPLAY=16'h0000, STAR=0, DIGIT_CNT=0, ENTRY_BUSY=0, state=IDLE, timer=0. RST overrides every other input.
- Input path:
  - KEY_PRESS and KEY_CODE pass through a 2-flop synchronizer.
  - A key event is the rising edge of the synchronized KEY_PRESS, with the synchronized KEY_CODE captured in the same cycle.
  - Latency from raw edge to state update is 3 cycles (no debounce).
  - Holding a key generates exactly one event; release generates none.
- States: IDLE, ENTRY, SUBMIT, LOCKED.
- IDLE (DIGIT_CNT=0):
  - Digit d: DISPLAY={12'h000,d}, DIGIT_CNT=1, go to ENTRY.
  - '*', '#', C-F: ignored.
- ENTRY:
  - Digit with DIGIT_CNT<4: DISPLAY={DISPLAY[11:0],d}, DIGIT_CNT+1.
  - Digit with DIGIT_CNT==4: ignored; no wrap, no shift.
  - '*' with DIGIT_CNT==4: go to SUBMIT.
  - '*' with DIGIT_CNT<4: ignored; the entry is kept.
  - '#': DISPLAY=0, DIGIT_CNT=0, go to IDLE.
  - Timer reloads to 0 on every accepted event, including ignored codes. When the timer reaches TIMEOUT_CYCLES-1 with no event, clear to IDLE.
  - A key event and timeout expiry in the same cycle: the key event wins and the timer reloads.
- SUBMIT (exactly 1 cycle):
  - STAR=1, DISPLAY unchanged.
  - Next cycle: DISPLAY=0, DIGIT_CNT=0, STAR=0, go to IDLE.
  - Key events arriving during SUBMIT are dropped.
- CLOSE_SENSOR=1 in ENTRY: clear to IDLE. It has no effect in SUBMIT; the submit completes.
- ALERT=1, from any state except reset: next state LOCKED, DISPLAY=0, DIGIT_CNT=0, STAR=0.
  - ALERT wins over a simultaneous key event or submit.
  - All keys are ignored while in LOCKED.
  - ALERT falling edge: go to IDLE.
  - A key still held at unlock does not produce an event; a fresh rising edge is required.
- ENTRY_BUSY = (state==ENTRY) || (state==SUBMIT).
- Timer width: 32 bits, saturating. It does not count in IDLE or LOCKED.

Optional Feature:
- Macro: KEYPAD_DEBOUNCE_EN.
- When defined: the synchronized KEY_PRESS must hold a constant level for DEBOUNCE_CYCLES consecutive cycles before the debounced level changes.
  - Events are rising edges of the debounced level.
  - KEY_CODE is sampled when the debounced level rises.
  - Latency is 3+DEBOUNCE_CYCLES cycles.
- When undefined: no debounce counter exists and DEBOUNCE_CYCLES is unused.

Decomposition:
- Package keypad_pkg holds:
  - key code constants: KEY_STAR=4'hA, KEY_HASH=4'hB.
  - the state encoding (IDLE, ENTRY, SUBMIT, LOCKED).
  - PW_DIGITS=4 and DISPLAY_W=16.
- Sub-module key_event_detect contains the synchronizer, optional debounce and rising-edge detect. It outputs KEY_EVT (1-cycle pulse) and KEY_VAL[3:0].
- keypad_entry holds the FSM, shift register and timer.

Test Plan:
- Press 1,2,3,4 then '*' -> DISPLAY=16'h1234 with STAR=1 for exactly 1 cycle; next cycle DISPLAY=0, DIGIT_CNT=0.
- Press 5,6,7,8,9 then '*' -> 9 ignored, DISPLAY=16'h5678 at STAR; press 1,2 then '*' -> no STAR, DISPLAY=16'h0012 retained.
- Press 3,4 then '#' -> DISPLAY=0, IDLE; press 7 then idle for TIMEOUT_CYCLES (set 100 in bench) -> DISPLAY clears at cycle 100, not 99.
- Enter 4 digits, assert ALERT in the same cycle as the '*' event -> no STAR, DISPLAY=0; keys during ALERT ignored; after ALERT falls, a held key produces no event.
- Hold KEY_PRESS 1000 cycles -> exactly one digit accepted; RST mid-entry with DIGIT_CNT=3 -> all outputs 0 next cycle.
- With KEYPAD_DEBOUNCE_EN and DEBOUNCE_CYCLES=8, toggle KEY_PRESS every 3 cycles -> no events; hold 8 cycles -> one event.
